// File: rtl/bottling_pkg.sv
// Shared state encoding, alarm codes and default sizing for the bottling line controller.
package bottling_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_MOVE = 3'd1;
   localparam state_t ST_FILL = 3'd2;
   localparam state_t ST_SEAL = 3'd3;
   localparam state_t ST_EXIT = 3'd4;
   localparam state_t ST_HALT = 3'd5;

   localparam logic [1:0] ALARM_NONE    = 2'b00;
   localparam logic [1:0] ALARM_TRAY    = 2'b01;
   localparam logic [1:0] ALARM_TIMEOUT = 2'b10;

   localparam int DEF_TRAY_CAP     = 20;
   localparam int DEF_TRAY_LOW     = 5;
   localparam int DEF_REFILL       = 20;
   localparam int DEF_DISP_STOCK   = 60;
   localparam int DEF_PACK_SIZE    = 12;
   localparam int DEF_CNT_W        = 8;
   localparam int DEF_FILL_TIMEOUT = 255;

endpackage

// File: rtl/cork_store.sv
// Cork tray and dispenser bookkeeping: consumption per sealed bottle plus
// automatic refills from the dispenser when the tray runs low.
module cork_store
   import bottling_pkg::*;
#(
   parameter int TRAY_CAP   = DEF_TRAY_CAP,
   parameter int TRAY_LOW   = DEF_TRAY_LOW,
   parameter int REFILL     = DEF_REFILL,
   parameter int DISP_STOCK = DEF_DISP_STOCK,
   parameter int CNT_W      = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             consume,
   output logic [CNT_W-1:0] tray_count,
   output logic [CNT_W-1:0] disp_count,
   output logic             ad
);

   logic [CNT_W-1:0] tray_reg, tray_next;
   logic [CNT_W-1:0] disp_reg, disp_next;
   logic [CNT_W-1:0] room, amount;
   logic             ad_reg, holdoff_reg, refill;

   // Amount is based on the pre-consume tray level, so a same-cycle consume
   // can only pull the result below TRAY_CAP, never above it.
   always_comb begin
      room   = CNT_W'(TRAY_CAP) - tray_reg;
      amount = CNT_W'(REFILL);
      if (disp_reg < amount) amount = disp_reg;
      if (room < amount)     amount = room;
      refill = (tray_reg <= CNT_W'(TRAY_LOW)) && (disp_reg != '0) &&
               !holdoff_reg && (amount != '0);
      tray_next = tray_reg;
      disp_next = disp_reg;
      if (consume) tray_next = tray_next - CNT_W'(1);
      if (refill) begin
         tray_next = tray_next + amount;
         disp_next = disp_reg - amount;
      end
   end

   // holdoff blocks the cycle right after a refill, spacing refills >= 2 cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         tray_reg    <= CNT_W'(TRAY_CAP);
         disp_reg    <= CNT_W'(DISP_STOCK);
         ad_reg      <= 1'b0;
         holdoff_reg <= 1'b0;
      end else begin
         tray_reg    <= tray_next;
         disp_reg    <= disp_next;
         ad_reg      <= refill;
         holdoff_reg <= refill;
      end
   end

   assign tray_count = tray_reg;
   assign disp_count = disp_reg;
   assign ad         = ad_reg;

endmodule

// File: rtl/bottling_line_ctrl.sv
// Bottling line sequencer: move / fill / seal / exit FSM with Moore registered
// outputs and pack counting. Define BOTTLING_FILL_TIMEOUT_EN to add the fill timeout.
module bottling_line_ctrl
   import bottling_pkg::*;
#(
   parameter int TRAY_CAP     = DEF_TRAY_CAP,
   parameter int TRAY_LOW     = DEF_TRAY_LOW,
   parameter int REFILL       = DEF_REFILL,
   parameter int DISP_STOCK   = DEF_DISP_STOCK,
   parameter int PACK_SIZE    = DEF_PACK_SIZE,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pg,
   input  logic             ch,
   input  logic             ro,
   output logic             m,
   output logic             ev,
   output logic             ve,
   output logic             gp,
   output logic             ad,
   output logic             alarm,
   output logic [1:0]       alarm_code,
   output logic [CNT_W-1:0] tray_count,
   output logic [CNT_W-1:0] disp_count,
   output logic [CNT_W-1:0] pack_count,
   output logic [2:0]       state
);

   generate
      if (TRAY_CAP >= (1 << CNT_W) || TRAY_LOW >= (1 << CNT_W) ||
          REFILL >= (1 << CNT_W) || DISP_STOCK >= (1 << CNT_W) ||
          PACK_SIZE >= (1 << CNT_W) || PACK_SIZE < 1 ||
          FILL_TIMEOUT >= (1 << CNT_W) || FILL_TIMEOUT < 1) begin : g_bad_cfg
         $error("bottling_line_ctrl: parameter values do not fit CNT_W");
      end
   endgenerate

   state_t           state_reg, state_next;
   logic [1:0]       code_reg, code_next;
   logic             m_reg, ev_reg, ve_reg, gp_reg, alarm_reg;
   logic             consume;
   logic [CNT_W-1:0] bottle_reg, pack_reg;

`ifdef BOTTLING_FILL_TIMEOUT_EN
   logic [CNT_W-1:0] fill_cnt_reg;
`endif

   cork_store #(
      .TRAY_CAP(TRAY_CAP), .TRAY_LOW(TRAY_LOW), .REFILL(REFILL),
      .DISP_STOCK(DISP_STOCK), .CNT_W(CNT_W)
   ) u_cork_store (
      .clk(clk), .reset(reset), .consume(consume),
      .tray_count(tray_count), .disp_count(disp_count), .ad(ad)
   );

   always_comb begin
      state_next = state_reg;
      code_next  = code_reg;
      consume    = 1'b0;
      // Only HALT ignores the run request; everywhere else dropping enable idles.
      if (state_reg != ST_HALT && !enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: state_next = ST_MOVE;
            ST_MOVE: if (pg) state_next = ST_FILL;
            ST_FILL: begin
               if (ch) state_next = ST_SEAL;
`ifdef BOTTLING_FILL_TIMEOUT_EN
               else if (fill_cnt_reg == CNT_W'(FILL_TIMEOUT - 1)) begin
                  state_next = ST_HALT;
                  code_next  = ALARM_TIMEOUT;
               end
`endif
            end
            ST_SEAL: begin
               if (tray_count == '0) begin
                  state_next = ST_HALT;
                  code_next  = ALARM_TRAY;
               end else if (ro) begin
                  consume    = 1'b1;
                  state_next = ST_EXIT;
               end
            end
            ST_EXIT: if (!pg) state_next = ST_MOVE;
            ST_HALT: begin
               if (code_reg == ALARM_TRAY && tray_count != '0) begin
                  state_next = ST_SEAL;
                  code_next  = ALARM_NONE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Actuators are decoded from the next state so they change with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         code_reg   <= ALARM_NONE;
         m_reg      <= 1'b0;
         ev_reg     <= 1'b0;
         ve_reg     <= 1'b0;
         gp_reg     <= 1'b0;
         alarm_reg  <= 1'b0;
         bottle_reg <= '0;
         pack_reg   <= '0;
      end else begin
         state_reg <= state_next;
         code_reg  <= code_next;
         m_reg     <= (state_next == ST_MOVE) || (state_next == ST_EXIT);
         ev_reg    <= (state_next == ST_FILL);
         ve_reg    <= (state_next == ST_SEAL);
         gp_reg    <= consume;
         alarm_reg <= (state_next == ST_HALT);
         if (consume) begin
            if (bottle_reg == CNT_W'(PACK_SIZE - 1)) begin
               bottle_reg <= '0;
               pack_reg   <= pack_reg + CNT_W'(1);
            end else begin
               bottle_reg <= bottle_reg + CNT_W'(1);
            end
         end
      end
   end

`ifdef BOTTLING_FILL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset || state_reg != ST_FILL) fill_cnt_reg <= '0;
      else                               fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
   end
`endif

   assign m          = m_reg;
   assign ev         = ev_reg;
   assign ve         = ve_reg;
   assign gp         = gp_reg;
   assign alarm      = alarm_reg;
   assign alarm_code = code_reg;
   assign pack_count = pack_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_bottling_line_ctrl.sv
// Directed bench: a default line and a line with an empty dispenser share stimulus.
module tb_bottling_line_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic reset, enable, pg, ch, ro;

   logic         m, ev, ve, gp, ad, alarm;
   logic [1:0]   alarm_code;
   logic [W-1:0] tray_count, disp_count, pack_count;
   logic [2:0]   state;

   logic         e_m, e_ev, e_ve, e_gp, e_ad, e_alarm;
   logic [1:0]   e_alarm_code;
   logic [W-1:0] e_tray_count, e_disp_count, e_pack_count;
   logic [2:0]   e_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bottling_line_ctrl #(.FILL_TIMEOUT(10)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pg(pg), .ch(ch), .ro(ro),
      .m(m), .ev(ev), .ve(ve), .gp(gp), .ad(ad), .alarm(alarm),
      .alarm_code(alarm_code), .tray_count(tray_count), .disp_count(disp_count),
      .pack_count(pack_count), .state(state)
   );

   bottling_line_ctrl #(.DISP_STOCK(0), .FILL_TIMEOUT(10)) dut_e (
      .clk(clk), .reset(reset), .enable(enable), .pg(pg), .ch(ch), .ro(ro),
      .m(e_m), .ev(e_ev), .ve(e_ve), .gp(e_gp), .ad(e_ad), .alarm(e_alarm),
      .alarm_code(e_alarm_code), .tray_count(e_tray_count), .disp_count(e_disp_count),
      .pack_count(e_pack_count), .state(e_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One bottle starting from MOVE, ending back in MOVE.
   task automatic bottle(input int n);
      pg = 1'b1; tick();
      ch = 1'b1; tick();
      ch = 1'b0; ro = 1'b1; tick();
      chk($sformatf("gp_bottle%0d", n), {31'd0, gp}, 32'd1);
      chk($sformatf("e_tray_bottle%0d", n), {24'd0, e_tray_count}, 32'(20 - n));
      pg = 1'b0; ro = 1'b0; tick();
      $display("bottle %0d: tray=%0d disp=%0d pack=%0d ad=%0d", n, tray_count, disp_count,
               pack_count, ad);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; pg = 1'b0; ch = 1'b0; ro = 1'b0;
      tick(); tick();
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_tray", {24'd0, tray_count}, 32'd20);
      chk("rst_disp", {24'd0, disp_count}, 32'd60);
      chk("rst_pack", {24'd0, pack_count}, 32'd0);
      chk("rst_act", {28'd0, m, ev, ve, gp}, 32'd0);
      chk("rst_alarm", {29'd0, alarm, alarm_code}, 32'd0);
      chk("rst_e_disp", {24'd0, e_disp_count}, 32'd0);

      // First bottle, walked one state at a time
      reset = 1'b0; enable = 1'b1; tick();
      chk("b1_move", {29'd0, state}, 32'd1);
      chk("b1_move_m", {31'd0, m}, 32'd1);
      pg = 1'b1; tick();
      chk("b1_fill", {29'd0, state}, 32'd2);
      chk("b1_fill_act", {29'd0, m, ev, ve}, 32'b010);
      ch = 1'b1; tick();
      chk("b1_seal", {29'd0, state}, 32'd3);
      chk("b1_seal_ve", {31'd0, ve}, 32'd1);
      ch = 1'b0; ro = 1'b1; tick();
      chk("b1_exit", {29'd0, state}, 32'd4);
      chk("b1_gp", {31'd0, gp}, 32'd1);
      chk("b1_tray", {24'd0, tray_count}, 32'd19);
      pg = 1'b0; ro = 1'b0; tick();
      chk("b1_back_move", {29'd0, state}, 32'd1);
      chk("b1_gp_low", {31'd0, gp}, 32'd0);
      $display("bottle 1: tray=%0d state=%0d", tray_count, state);

      for (int i = 2; i <= 20; i++) begin
         bottle(i);
         if (i == 11) chk("pack_b11", {24'd0, pack_count}, 32'd0);
         if (i == 12) chk("pack_b12", {24'd0, pack_count}, 32'd1);
         if (i == 14) chk("tray_b14", {24'd0, tray_count}, 32'd6);
         if (i == 15) begin
            // tray reached 5 on the EXIT edge; refill of min(20,60,15) lands next edge
            chk("refill_ad", {31'd0, ad}, 32'd1);
            chk("refill_tray", {24'd0, tray_count}, 32'd20);
            chk("refill_disp", {24'd0, disp_count}, 32'd45);
         end
         if (i == 16) chk("refill_ad_once", {31'd0, ad}, 32'd0);
      end
      chk("b20_tray", {24'd0, tray_count}, 32'd15);
      chk("b20_e_tray", {24'd0, e_tray_count}, 32'd0);

      // 21st bottle: the empty line halts in SEAL
      pg = 1'b1; tick();
      ch = 1'b1; tick();
      chk("b21_e_seal", {29'd0, e_state}, 32'd3);
      ch = 1'b0; ro = 1'b1; tick();
      chk("b21_e_halt", {29'd0, e_state}, 32'd5);
      chk("b21_e_alarm", {31'd0, e_alarm}, 32'd1);
      chk("b21_e_code", {30'd0, e_alarm_code}, 32'b01);
      chk("b21_e_act", {29'd0, e_m, e_ev, e_ve}, 32'd0);
      chk("b21_tray", {24'd0, tray_count}, 32'd14);
      pg = 1'b0; ro = 1'b0; tick();
      $display("bottle 21: tray=%0d e_state=%0d e_code=%0d", tray_count, e_state, e_alarm_code);

      // Drop enable during FILL
      pg = 1'b1; tick();
      chk("en_fill", {29'd0, state}, 32'd2);
      enable = 1'b0; tick();
      chk("en_idle", {29'd0, state}, 32'd0);
      chk("en_ev", {31'd0, ev}, 32'd0);
      chk("en_tray", {24'd0, tray_count}, 32'd14);
      chk("en_disp", {24'd0, disp_count}, 32'd45);
      chk("en_pack", {24'd0, pack_count}, 32'd1);
      chk("en_e_halt", {29'd0, e_state}, 32'd5);
      pg = 1'b0; enable = 1'b1; tick();
      chk("en_move", {29'd0, state}, 32'd1);
      $display("enable drop: state=%0d tray=%0d", state, tray_count);

      // Fill without ch: ten FILL cycles then timeout (when enabled)
      pg = 1'b1; tick();
      for (int i = 0; i < 9; i++) tick();
      chk("to_still_fill", {29'd0, state}, 32'd2);
      tick();
`ifdef BOTTLING_FILL_TIMEOUT_EN
      chk("to_state", {29'd0, state}, 32'd5);
      chk("to_code", {30'd0, alarm_code}, 32'b10);
      chk("to_alarm", {31'd0, alarm}, 32'd1);
`else
      chk("to_state", {29'd0, state}, 32'd2);
      chk("to_code", {30'd0, alarm_code}, 32'b00);
      chk("to_alarm", {31'd0, alarm}, 32'd0);
`endif
      tick(); tick();
      chk("e_halt_hold", {29'd0, e_state}, 32'd5);
      $display("fill wait: state=%0d code=%0d", state, alarm_code);

      // Reset mid-operation
      reset = 1'b1; tick();
      chk("rst2_state", {29'd0, state}, 32'd0);
      chk("rst2_tray", {24'd0, tray_count}, 32'd20);
      chk("rst2_disp", {24'd0, disp_count}, 32'd60);
      chk("rst2_pack", {24'd0, pack_count}, 32'd0);
      chk("rst2_e_state", {29'd0, e_state}, 32'd0);
      chk("rst2_e_alarm", {29'd0, e_alarm, e_alarm_code}, 32'd0);
      chk("rst2_e_tray", {24'd0, e_tray_count}, 32'd20);
      $display("reset: state=%0d e_state=%0d", state, e_state);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
